// File: rtl/mips_decode_execute_if.sv
// mips_decode_execute_if
//   Bundles the operand/instruction inputs and the registered decode/execute
//   results of the mips_decode_execute slice.
//   Inputs to the slice : instr, pc, rd1, rd2
//   Outputs of the slice: alu_result, zero, pc_plus4, pc_next, write_reg,
//                         mem_to_reg, mem_write, reg_write, alu_src, reg_dst,
//                         jump, jump_reg, link, branch_taken, alu_control,
//                         illegal
//   master: the side that presents instructions (fetch/regfile side)
//   slave : the decode/execute slice itself
interface mips_decode_execute_if;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [4:0]  write_reg;
    logic        mem_to_reg;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src;
    logic        reg_dst;
    logic        jump;
    logic        jump_reg;
    logic        link;
    logic        branch_taken;
    logic [4:0]  alu_control;
    logic        illegal;

    modport master (
        output instr, pc, rd1, rd2,
        input  alu_result, zero, pc_plus4, pc_next, write_reg,
               mem_to_reg, mem_write, reg_write, alu_src, reg_dst,
               jump, jump_reg, link, branch_taken, alu_control, illegal
    );

    modport slave (
        input  instr, pc, rd1, rd2,
        output alu_result, zero, pc_plus4, pc_next, write_reg,
               mem_to_reg, mem_write, reg_write, alu_src, reg_dst,
               jump, jump_reg, link, branch_taken, alu_control, illegal
    );
endinterface

// File: rtl/mips_decode_execute.sv
// mips_decode_execute
//   Single-cycle MIPS decode/execute slice: control unit, 32-bit ALU,
//   PC+4 adder, branch-target adder and next-PC selection. Every result is
//   registered once, so outputs reflect the inputs sampled on the previous
//   rising edge.
//   Ports:
//     clock - rising-edge clock
//     reset - synchronous, active-high; clears every output
//     bus   - mips_decode_execute_if.slave (instr/pc/rd1/rd2 in, results out)
module mips_decode_execute (
    input  logic                        clock,
    input  logic                        reset,
    mips_decode_execute_if.slave        bus
);

    typedef enum logic [4:0] {
        ALU_AND  = 5'b00000,
        ALU_OR   = 5'b00001,
        ALU_ADD  = 5'b00010,
        ALU_XOR  = 5'b00011,
        ALU_NOR  = 5'b00100,
        ALU_SUB  = 5'b00110,
        ALU_SLT  = 5'b00111,
        ALU_SLL  = 5'b01000,
        ALU_SRL  = 5'b01001,
        ALU_SRA  = 5'b01010,
        ALU_SLTU = 5'b01011,
        ALU_LUI  = 5'b01100
    } alu_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic        zero;
        logic [31:0] pc_plus4;
        logic [31:0] pc_next;
        logic [4:0]  write_reg;
        logic        mem_to_reg;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        logic        reg_dst;
        logic        jump;
        logic        jump_reg;
        logic        link;
        logic        branch_taken;
        logic [4:0]  alu_control;
        logic        illegal;
    } out_t;

    out_t out_d;
    out_t out_q;

    // Control unit outputs
    logic    mem_to_reg, mem_write, reg_write, alu_src, reg_dst;
    logic    jump, jump_reg, link, illegal;
    logic    is_beq, is_bne, use_zero_imm;
    alu_op_e alu_op;

    logic [5:0] opcode;
    logic [5:0] funct;
    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        mem_to_reg   = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        reg_dst      = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        link         = 1'b0;
        illegal      = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        use_zero_imm = 1'b0;
        alu_op       = ALU_AND;

        case (opcode)
            6'h00: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_op = ALU_ADD;
                    6'h22, 6'h23: alu_op = ALU_SUB;
                    6'h24:        alu_op = ALU_AND;
                    6'h25:        alu_op = ALU_OR;
                    6'h26:        alu_op = ALU_XOR;
                    6'h27:        alu_op = ALU_NOR;
                    6'h2A:        alu_op = ALU_SLT;
                    6'h2B:        alu_op = ALU_SLTU;
                    6'h00:        alu_op = ALU_SLL;
                    6'h02:        alu_op = ALU_SRL;
                    6'h03:        alu_op = ALU_SRA;
                    6'h08: begin
                        jump_reg  = 1'b1;
                        reg_write = 1'b0;
                    end
                    default: begin
                        // Unknown funct: behave as a NOP with no controls set
                        illegal   = 1'b1;
                        reg_dst   = 1'b0;
                        reg_write = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_ADD; end
            6'h0A:        begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_SLT; end
            6'h0C: begin alu_src = 1'b1; reg_write = 1'b1; use_zero_imm = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin alu_src = 1'b1; reg_write = 1'b1; use_zero_imm = 1'b1; alu_op = ALU_OR;  end
            6'h0E: begin alu_src = 1'b1; reg_write = 1'b1; use_zero_imm = 1'b1; alu_op = ALU_XOR; end
            6'h0F:        begin alu_src = 1'b1; reg_write = 1'b1; alu_op = ALU_LUI; end
            6'h23: begin
                alu_src    = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_op     = ALU_ADD;
            end
            6'h2B: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                alu_op    = ALU_ADD;
            end
            6'h04: begin is_beq = 1'b1; alu_op = ALU_SUB; end
            6'h05: begin is_bne = 1'b1; alu_op = ALU_SUB; end
            6'h02: jump = 1'b1;
            6'h03: begin
                jump      = 1'b1;
                link      = 1'b1;
                reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU, PC arithmetic and next-PC selection
    // ------------------------------------------------------------------
    logic [31:0] sign_imm, zero_imm, alu_b, alu_y;
    logic [31:0] pc_plus4, branch_target, jump_target, pc_next;
    logic [4:0]  shamt, write_reg;
    logic        zero, branch_taken;

    assign sign_imm = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign zero_imm = {16'h0000, bus.instr[15:0]};
    assign shamt    = bus.instr[10:6];
    assign alu_b    = alu_src ? (use_zero_imm ? zero_imm : sign_imm) : bus.rd2;

    always_comb begin
        alu_y = 32'h0;
        case (alu_op)
            ALU_AND:  alu_y = bus.rd1 & alu_b;
            ALU_OR:   alu_y = bus.rd1 | alu_b;
            ALU_ADD:  alu_y = bus.rd1 + alu_b;
            ALU_XOR:  alu_y = bus.rd1 ^ alu_b;
            ALU_NOR:  alu_y = ~(bus.rd1 | alu_b);
            ALU_SUB:  alu_y = bus.rd1 - alu_b;
            ALU_SLT:  alu_y = {31'h0, $signed(bus.rd1) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'h0, bus.rd1 < alu_b};
            ALU_SLL:  alu_y = alu_b << shamt;
            ALU_SRL:  alu_y = alu_b >> shamt;
            ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> shamt);
            ALU_LUI:  alu_y = {alu_b[15:0], 16'h0000};
            default:  alu_y = 32'h0;
        endcase
    end

    assign zero          = (alu_y == 32'h0);
    assign branch_taken  = (is_beq & zero) | (is_bne & ~zero);
    assign pc_plus4      = bus.pc + 32'd4;
    assign branch_target = pc_plus4 + {sign_imm[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], bus.instr[25:0], 2'b00};

    always_comb begin
        if (jump_reg)          pc_next = bus.rd1;
        else if (jump)         pc_next = jump_target;
        else if (branch_taken) pc_next = branch_target;
        else                   pc_next = pc_plus4;
    end

    always_comb begin
        if (link)         write_reg = 5'd31;
        else if (reg_dst) write_reg = bus.instr[15:11];
        else              write_reg = bus.instr[20:16];
    end

    always_comb begin
        out_d.alu_result   = alu_y;
        out_d.zero         = zero;
        out_d.pc_plus4     = pc_plus4;
        out_d.pc_next      = pc_next;
        out_d.write_reg    = write_reg;
        out_d.mem_to_reg   = mem_to_reg;
        out_d.mem_write    = mem_write;
        out_d.reg_write    = reg_write;
        out_d.alu_src      = alu_src;
        out_d.reg_dst      = reg_dst;
        out_d.jump         = jump;
        out_d.jump_reg     = jump_reg;
        out_d.link         = link;
        out_d.branch_taken = branch_taken;
        out_d.alu_control  = alu_op;
        out_d.illegal      = illegal;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment so every flop samples values from
        // before this edge, independent of statement order.
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign bus.alu_result   = out_q.alu_result;
    assign bus.zero         = out_q.zero;
    assign bus.pc_plus4     = out_q.pc_plus4;
    assign bus.pc_next      = out_q.pc_next;
    assign bus.write_reg    = out_q.write_reg;
    assign bus.mem_to_reg   = out_q.mem_to_reg;
    assign bus.mem_write    = out_q.mem_write;
    assign bus.reg_write    = out_q.reg_write;
    assign bus.alu_src      = out_q.alu_src;
    assign bus.reg_dst      = out_q.reg_dst;
    assign bus.jump         = out_q.jump;
    assign bus.jump_reg     = out_q.jump_reg;
    assign bus.link         = out_q.link;
    assign bus.branch_taken = out_q.branch_taken;
    assign bus.alu_control  = out_q.alu_control;
    assign bus.illegal      = out_q.illegal;

endmodule

// File: tb/tb_mips_decode_execute.sv
// tb_mips_decode_execute
//   Directed-vector bench for mips_decode_execute. Each step presents one
//   instruction, waits for the registering edge and checks the outputs
//   against hand-computed values.
module tb_mips_decode_execute;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_mis;

    mips_decode_execute_if bus ();

    mips_decode_execute dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Controls packed as {mem_to_reg, mem_write, reg_write, alu_src, reg_dst,
    //                     jump, jump_reg, link, branch_taken, illegal}
    function automatic logic [9:0] ctrl_vec();
        return {bus.mem_to_reg, bus.mem_write, bus.reg_write, bus.alu_src,
                bus.reg_dst, bus.jump, bus.jump_reg, bus.link,
                bus.branch_taken, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rd1, input logic [31:0] rd2);
        bus.instr = instr;
        bus.pc    = pc;
        bus.rd1   = rd1;
        bus.rd2   = rd2;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_result"}, bus.alu_result, 32'h0);
        check({tag, ".pc_plus4"},   bus.pc_plus4,   32'h0);
        check({tag, ".pc_next"},    bus.pc_next,    32'h0);
        check({tag, ".misc"},
              {14'h0, bus.zero, bus.write_reg, bus.alu_control, ctrl_vec()},
              32'h0);
    endtask

    initial begin
        n_cmp     = 0;
        n_mis     = 0;
        reset     = 1'b1;
        bus.instr = 32'h0;
        bus.pc    = 32'h0;
        bus.rd1   = 32'h0;
        bus.rd2   = 32'h0;

        // Reset with an arbitrary instruction present
        apply(32'h00221820, 32'h0000_0040, 32'd5, 32'd7);
        check_all_zero("reset");
        reset = 1'b0;

        // add $3,$1,$2
        apply(32'h00221820, 32'h0000_0040, 32'd5, 32'd7);
        check("add.result",    bus.alu_result, 32'd12);
        check("add.ctrl",      {22'h0, ctrl_vec()}, 32'b00_1010_0000);
        check("add.write_reg", {27'h0, bus.write_reg}, 32'd3);
        check("add.pc_next",   bus.pc_next, 32'h0000_0044);
        check("add.alu_ctl",   {27'h0, bus.alu_control}, 32'b00010);

        // sub / slt / sltu
        apply(32'h00221822, 32'h0, 32'd3, 32'd5);
        check("sub.result", bus.alu_result, 32'hFFFF_FFFE);
        check("sub.zero",   {31'h0, bus.zero}, 32'd0);
        apply(32'h0022182A, 32'h0, 32'd3, 32'd5);
        check("slt.result", bus.alu_result, 32'd1);
        apply(32'h0022182B, 32'h0, 32'hFFFF_FFFF, 32'd1);
        check("sltu.result", bus.alu_result, 32'd0);
        check("sltu.zero",   {31'h0, bus.zero}, 32'd1);

        // sra $3,$2,4 keeps sign
        apply(32'h00021903, 32'h0, 32'h0, 32'h8000_0000);
        check("sra.result", bus.alu_result, 32'hF800_0000);

        // ori zero-extends; lui places the immediate high
        apply(32'h34228000, 32'h0, 32'h0, 32'h0);
        check("ori.result", bus.alu_result, 32'h0000_8000);
        apply(32'h3C021234, 32'h0, 32'h0, 32'h0);
        check("lui.result",    bus.alu_result, 32'h1234_0000);
        check("lui.write_reg", {27'h0, bus.write_reg}, 32'd2);

        // beq taken back to itself; bne falls through
        apply(32'h1022FFFF, 32'h0000_0100, 32'd9, 32'd9);
        check("beq.taken",   {31'h0, bus.branch_taken}, 32'd1);
        check("beq.pc_next", bus.pc_next, 32'h0000_0100);
        check("beq.ctrl",    {22'h0, ctrl_vec()}, 32'b00_0000_0010);
        apply(32'h1422FFFF, 32'h0000_0100, 32'd9, 32'd9);
        check("bne.taken",   {31'h0, bus.branch_taken}, 32'd0);
        check("bne.pc_next", bus.pc_next, 32'h0000_0104);

        // jal / jr
        apply(32'h0C000040, 32'h0040_0000, 32'h0, 32'h0);
        check("jal.pc_next",   bus.pc_next, 32'h0000_0100);
        check("jal.write_reg", {27'h0, bus.write_reg}, 32'd31);
        check("jal.ctrl",      {22'h0, ctrl_vec()}, 32'b00_1001_0100);
        check("jal.pc_plus4",  bus.pc_plus4, 32'h0040_0004);
        apply(32'h00200008, 32'h0000_0200, 32'h0000_1234, 32'h0);
        check("jr.pc_next", bus.pc_next, 32'h0000_1234);
        check("jr.ctrl",    {22'h0, ctrl_vec()}, 32'b00_0010_1000);

        // lw / sw
        apply(32'h8C22FFFC, 32'h0, 32'h0000_1000, 32'h0);
        check("lw.result", bus.alu_result, 32'h0000_0FFC);
        check("lw.ctrl",   {22'h0, ctrl_vec()}, 32'b10_1100_0000);
        apply(32'hAC22FFFC, 32'h0, 32'h0000_1000, 32'h0);
        check("sw.result", bus.alu_result, 32'h0000_0FFC);
        check("sw.ctrl",   {22'h0, ctrl_vec()}, 32'b01_0100_0000);

        // pc wrap at 2^32
        apply(32'h00221820, 32'hFFFF_FFFC, 32'd0, 32'd0);
        check("wrap.pc_plus4", bus.pc_plus4, 32'h0);
        check("wrap.pc_next",  bus.pc_next,  32'h0);

        // Unsupported opcode executes as a NOP
        apply(32'hFC000000, 32'h0000_0300, 32'h0, 32'h0);
        check("ill.ctrl",    {22'h0, ctrl_vec()}, 32'b00_0000_0001);
        check("ill.alu_ctl", {27'h0, bus.alu_control}, 32'd0);
        check("ill.pc_next", bus.pc_next, 32'h0000_0304);

        // Unsupported funct
        apply(32'h0022183F, 32'h0000_0300, 32'h0, 32'h0);
        check("illf.ctrl", {22'h0, ctrl_vec()}, 32'b00_0000_0001);

        // Reset wins over a live instruction in the same cycle
        reset = 1'b1;
        apply(32'hFC000000, 32'h0000_0300, 32'h5, 32'h6);
        check_all_zero("reset2");
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
